// File: rtl/code_pack.sv
// code_pack: packs decoded instruction fields into {op, param_a, param_b} code
// words and queues them in a small FIFO that drains toward the parse stage.
// Optional build macro: CODE_PACK_OP_CHECK_EN drops opcodes >= op_count and
// pulses err for one cycle.
module code_pack #(
  parameter int unsigned op_size      = 4,
  parameter int unsigned param_a_size = 4,
  parameter int unsigned param_b_size = 4,
  parameter int unsigned depth        = 4,
  parameter int unsigned op_count     = 8
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [op_size-1:0]                        in_op,
  input  logic [param_a_size-1:0]                   in_act,
  input  logic [param_b_size-1:0]                   in_dense,
  input  logic [param_a_size+param_b_size-1:0]      in_cost,
  input  logic                                      in_wide,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [op_size+param_a_size+param_b_size-1:0] out_code,
  output logic [$clog2(depth):0]                    level,
  output logic                                      err
);

  localparam int unsigned CodeW = op_size + param_a_size + param_b_size;
  localparam int unsigned PtrW  = $clog2(depth);
  localparam int unsigned LvlW  = PtrW + 1;

  logic [CodeW-1:0] mem_q [depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]  level_q, level_d;
  logic [CodeW-1:0] code;
  logic             push, pop, op_ok, write;

  // Encode the incoming field set into a code word.
  always_comb begin
    code = in_wide ? {in_op, in_cost} : {in_op, in_act, in_dense};
  end

`ifdef CODE_PACK_OP_CHECK_EN
  // Opcode range check gates the FIFO write, not the handshake.
  always_comb begin
    op_ok = (32'(in_op) < op_count);
  end
`else
  logic unused_op_count;
  assign unused_op_count = ^op_count;

  // Every accepted word is legal without the check.
  always_comb begin
    op_ok = 1'b1;
  end
`endif

  // Handshake decode; in_ready depends only on registered occupancy.
  always_comb begin
    in_ready  = (level_q != LvlW'(depth));
    out_valid = (level_q != '0);
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
    write     = push && op_ok;
    out_code  = out_valid ? mem_q[rd_ptr_q] : '0;
    level     = level_q;
  end

  // Next-state for pointers and occupancy.
  always_comb begin
    wr_ptr_d = write ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = level_q;
    unique case ({write, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (write) begin
      mem_q[wr_ptr_q] <= code;
    end
  end

`ifdef CODE_PACK_OP_CHECK_EN
  logic err_q;

  // One-cycle error pulse after a rejected accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= push && !op_ok;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_code_pack.sv
// Directed self-checking bench for code_pack (default parameters).
module tb_code_pack;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [3:0]  in_act;
  logic [3:0]  in_dense;
  logic [7:0]  in_cost;
  logic        in_wide;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_code;
  logic [2:0]  level;
  logic        err;

  int checks = 0;
  int errors = 0;
  logic [11:0] exp_q[$];
  logic [11:0] words [5];

  code_pack dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_act    (in_act),
    .in_dense  (in_dense),
    .in_cost   (in_cost),
    .in_wide   (in_wide),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_code  (out_code),
    .level     (level),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, expv);
      $error("check %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [3:0] act, input logic [3:0] dense,
                       input logic [7:0] cost, input logic wide);
    in_op    = op;
    in_act   = act;
    in_dense = dense;
    in_cost  = cost;
    in_wide  = wide;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive(4'h0, 4'h0, 4'h0, 8'h00, 1'b0);
    repeat (2) step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_code", 32'(out_code), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    step();

    // Narrow encode
    drive(4'h3, 4'h5, 4'hA, 8'h00, 1'b0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("narrow_valid", 32'(out_valid), 32'd1);
    chk("narrow_code", 32'(out_code), 32'h35A);
    chk("narrow_level", 32'(level), 32'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("pop_level", 32'(level), 32'd0);
    chk("pop_code", 32'(out_code), 32'd0);
    chk("pop_valid", 32'(out_valid), 32'd0);

    // Wide encode ignores act/dense
    drive(4'h2, 4'hF, 4'hF, 8'hC7, 1'b1);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("wide_code", 32'(out_code), 32'h2C7);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("wide_drain", 32'(level), 32'd0);

    // Fill past capacity with out_ready low
    for (int i = 0; i < 5; i++) begin
      words[i] = {4'(i + 1), 4'(i), 4'(15 - i)};
      drive(4'(i + 1), 4'(i), 4'(15 - i), 8'h00, 1'b0);
      in_valid = 1'b1;
      chk($sformatf("fill_ready_%0d", i), 32'(in_ready), (i < 4) ? 32'd1 : 32'd0);
      step();
    end
    chk("full_level", 32'(level), 32'd4);
    chk("full_ready", 32'(in_ready), 32'd0);
    chk("full_head", 32'(out_code), 32'(words[0]));
    // Full and popping with in_valid still high: pop only
    out_ready = 1'b1;
    chk("full_pop_ready", 32'(in_ready), 32'd0);
    step();
    in_valid = 1'b0;
    chk("full_pop_level", 32'(level), 32'd3);
    for (int k = 1; k < 4; k++) begin
      chk($sformatf("drain_code_%0d", k), 32'(out_code), 32'(words[k]));
      step();
    end
    out_ready = 1'b0;
    chk("drain_valid", 32'(out_valid), 32'd0);
    chk("drain_level", 32'(level), 32'd0);

    // Steady push+pop at level 2
    for (int i = 0; i < 2; i++) begin
      drive(4'hA, 4'(i), 4'h1, 8'h00, 1'b0);
      exp_q.push_back({4'hA, 4'(i), 4'h1});
      in_valid = 1'b1;
      step();
    end
    chk("steady_start", 32'(level), 32'd2);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(4'hB, 4'(i), 4'(3 * i), 8'h00, 1'b0);
      chk($sformatf("steady_code_%0d", i), 32'(out_code), 32'(exp_q[0]));
      void'(exp_q.pop_front());
      exp_q.push_back({4'hB, 4'(i), 4'(3 * i)});
      step();
      chk($sformatf("steady_level_%0d", i), 32'(level), 32'd2);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("steady_tail_%0d", i), 32'(out_code), 32'(exp_q[0]));
      void'(exp_q.pop_front());
      step();
    end
    out_ready = 1'b0;
    chk("steady_empty", 32'(out_valid), 32'd0);

    // Opcode range
    drive(4'h9, 4'h1, 4'h2, 8'h00, 1'b0);
    in_valid = 1'b1;
    chk("op9_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
`ifdef CODE_PACK_OP_CHECK_EN
    chk("op9_err", 32'(err), 32'd1);
    chk("op9_level", 32'(level), 32'd0);
    step();
    chk("op9_err_clear", 32'(err), 32'd0);
`else
    chk("op9_err", 32'(err), 32'd0);
    chk("op9_level", 32'(level), 32'd1);
    chk("op9_code", 32'(out_code), 32'h912);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
`endif
    drive(4'h7, 4'h3, 4'h4, 8'h00, 1'b0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("op7_err", 32'(err), 32'd0);
    chk("op7_level", 32'(level), 32'd1);
    chk("op7_code", 32'(out_code), 32'h734);

    // Reset with 3 words queued
    for (int i = 0; i < 2; i++) begin
      drive(4'h1, 4'(i), 4'h0, 8'h00, 1'b0);
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    chk("pre_rst_level", 32'(level), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_level", 32'(level), 32'd0);
    chk("async_rst_ready", 32'(in_ready), 32'd1);
    chk("async_rst_code", 32'(out_code), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_level", 32'(level), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/code_pack.md
# code_pack

Instruction encoder and issue buffer for the neural-burning datapath. Accepts decoded instruction fields (opcode, activation type, dense type, or a wide cost type) over a valid/ready handshake. Packs them into the `{op, param_a, param_b}` code word consumed by the `parse` stage and queues the words in a small FIFO. The FIFO drains toward the parse stage over a second valid/ready handshake.

## Interface
- `op_size`, 4, opcode field width (code bits [MSB -: op_size])
- `param_a_size`, 4, activation-type field width (middle field)
- `param_b_size`, 4, dense-type field width (LSB field)
- `depth`, 4, FIFO entries; power of two, ≥ 2
- `op_count`, 8, number of legal opcodes (used only with the check macro)

Ports:
- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  field set present
- `in_ready`  out  1  encoder can accept
- `in_op`  in  op_size  opcode
- `in_act`  in  param_a_size  activation type
- `in_dense`  in  param_b_size  dense type
- `in_cost`  in  param_a_size+param_b_size  cost type (wide field)
- `in_wide`  in  1  1: low field comes from `in_cost`; 0: from `{in_act, in_dense}`
- `out_valid`  out  1  head code word available
- `out_ready`  in  1  downstream takes word
- `out_code`  out  op_size+param_a_size+param_b_size  head code word
- `level`  out  clog2(depth)+1  current occupancy
- `err`  out  1  one-cycle pulse on rejected opcode

## Operation
- Encoding: `code = in_wide ? {in_op, in_cost} : {in_op, in_act, in_dense}`. The word is combinational on the inputs and written at acceptance.
- Accept (push): `in_valid && in_ready`. Write the code at `wr_ptr`, then increment `wr_ptr` modulo `depth`.
- Issue (pop): `out_valid && out_ready`. Increment `rd_ptr` modulo `depth`.
- `in_ready = (level != depth)`. It is registered-state derived, so there is no combinational path from `out_ready`.
- `out_valid = (level != 0)`.
- `out_code = mem[rd_ptr]` when `out_valid`, otherwise 0.
- `level` update:
  - +1 on push only
  - −1 on pop only
  - unchanged on simultaneous push and pop
- Full and popping: `in_ready` stays 0 that cycle; no same-cycle refill.
- Empty and pushing: no bypass; the word appears on `out_code` the following cycle.
- Pointers use `clog2(depth)` bits and wrap naturally.
- Holding: while `out_valid && !out_ready`, `out_code` holds stable.
- Input fields are sampled only on the accepting edge.

## Timing
- Reset (`rst_n` low, asynchronous):
  - `wr_ptr`, `rd_ptr`, `level` = 0
  - `out_valid` = 0, `out_code` = 0
  - `in_ready` = 1 (combinationally, from `level` = 0)
  - `err` = 0
  - Memory contents are not reset.
- Reset mid-operation discards all queued words immediately. Release of `rst_n` is synchronous to `clk` upstream.
- Latency: a word accepted at edge N is visible with `out_valid` = 1 after edge N; the earliest pop is at edge N+1.
- Throughput: one push and one pop per cycle sustained when 0 < `level` < `depth`.

## Configuration
- `CODE_PACK_OP_CHECK_EN` defined:
  - An accepted field set with `in_op >= op_count` completes the handshake but is not written; `level` and `wr_ptr` are unchanged.
  - `err` pulses high for exactly the cycle after the accepting edge.
  - A simultaneous pop still proceeds.
- Undefined: every accepted word is written regardless of opcode; `err` is tied 0 and `op_count` is ignored.

## Test plan
- Reset, then push op=3, act=5, dense=A, wide=0 -> next cycle `out_valid`=1, `out_code`=12'h35A, `level`=1. Pop -> `level`=0, `out_code`=0.
- Push op=2, wide=1, cost=8'hC7, with act/dense=F/F -> `out_code`=12'h2C7 (act/dense ignored).
- Hold `out_ready`=0 and push 5 words with depth=4 -> `in_ready`=0 after the 4th, 5th word not taken, `level`=4. Pop all 4 -> words emerge in order, pointers wrap, `out_valid` drops after the 4th.
- At `level`=2, simultaneous push and pop for 6 cycles -> `level` stays 2, output order matches input order.
- At `level`=4 (full), assert `out_ready` with `in_valid`=1 -> pop occurs, no push that cycle, `level`=3.
- With `CODE_PACK_OP_CHECK_EN` and op_count=8: push op=9 -> handshake completes, `err`=1 for one cycle, `level` unchanged. Push op=7 -> stored, `err`=0. Assert `rst_n`=0 with 3 words queued -> `out_valid`=0 and `level`=0 immediately.
